// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// State and owner encodings live here so every user agrees on them.
package mem_bus_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 8;

   localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   // Returns data only when en is set, zero otherwise.
   function automatic logic [DATA_W-1:0] gate_data(input logic en, input logic [DATA_W-1:0] d);
      return en ? d : '0;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory side of the arbiter.
// Handshake: a requester raises req with stable fields and holds both until its
// one-cycle valid; the memory side sees ce held with stable fields until a one-cycle ack.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   logic              flush;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic              if_err;
   logic [DATA_W-1:0] if_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [SEL_W-1:0]  mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_valid;
   logic              mem_err;
   logic [DATA_W-1:0] mem_rdata;
   logic              stallreq_if;
   logic              stallreq_mem;
   logic              ram_ce;
   logic              ram_we;
   logic [SEL_W-1:0]  ram_sel;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_ack;

   modport slave (
      input  flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
             ram_rdata, ram_ack,
      output if_valid, if_err, if_rdata, mem_valid, mem_err, mem_rdata,
             stallreq_if, stallreq_mem, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
   );

   modport master (
      output flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
             ram_rdata, ram_ack,
      input  if_valid, if_err, if_rdata, mem_valid, mem_err, mem_rdata,
             stallreq_if, stallreq_mem, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction fetches and loads/stores onto one handshaked memory,
// with MEM priority, flush-drop of fetches and an access timeout.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_arbiter_if.slave bus,
   output state_t           dbg_state
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              drop_q, drop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_fire, mem_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            drop_d = 1'b0;
            // MEM wins ties: it belongs to the older instruction in the pipe.
            if (bus.mem_req) begin
               owner_d = OWN_MEM;
               we_d    = bus.mem_we;
               sel_d   = bus.mem_sel;
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               state_d = ST_ACC;
            end else if (bus.if_req && !bus.flush) begin
               owner_d = OWN_IF;
               we_d    = 1'b0;
               sel_d   = SEL_WORD;
               addr_d  = bus.if_addr;
               wdata_d = '0;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.flush && owner_q == OWN_IF) drop_d = 1'b1;
            if (bus.ram_ack) begin
               rdata_d = we_q ? '0 : bus.ram_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q + 1'b1 == TIMEOUT_C) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A flush arriving in the response cycle itself still suppresses the fetch.
   assign if_fire  = (state_q == ST_RESP) && (owner_q == OWN_IF) && !drop_q && !bus.flush;
   assign mem_fire = (state_q == ST_RESP) && (owner_q == OWN_MEM);

   assign bus.if_valid     = if_fire;
   assign bus.if_err       = if_fire & err_q;
   assign bus.if_rdata     = gate_data(if_fire, rdata_q);
   assign bus.mem_valid    = mem_fire;
   assign bus.mem_err      = mem_fire & err_q;
   assign bus.mem_rdata    = gate_data(mem_fire, rdata_q);
   assign bus.stallreq_if  = bus.if_req && !if_fire;
   assign bus.stallreq_mem = bus.mem_req && !mem_fire;
   assign bus.ram_ce       = (state_q == ST_ACC);
   assign bus.ram_we       = we_q;
   assign bus.ram_sel      = sel_q;
   assign bus.ram_addr     = addr_q;
   assign bus.ram_wdata    = wdata_q;

   assign dbg_state = state_q;

endmodule
